mat_vec_mul: RTL and testbench



---
 rtl/mat_vec_mul.sv | 64 ++++++
 tb/tb_mat_vec_mul.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mat_vec_mul.sv
// mat_vec_mul: sequential SIZE x SIZE matrix times SIZE-vector multiplier, one column per cycle.
// Ports:
//   clk     - clock, all state updates on the rising edge
//   reset   - asynchronous active-high reset, aborts any computation
//   start   - latch operands and begin; accepted only when idle or done
//   mtx_in  - matrix operand, mtx_in[i][j] is row i column j, unsigned 8-bit
//   vec_in  - vector operand, unsigned 8-bit elements
//   vec_out - accumulators, vec_out[i] = sum_j M[i][j]*V[j] mod 2^17, valid while done=1
//   done    - sticky result-valid flag, cleared by the next accepted start
module mat_vec_mul #(
    parameter int SIZE = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  mtx_in  [SIZE][SIZE],
    input  logic [7:0]  vec_in  [SIZE],
    output logic [16:0] vec_out [SIZE],
    output logic        done
);
    localparam int CW = SIZE > 1 ? $clog2(SIZE) : 1;
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);
    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
    state_t        state;
    logic [7:0]    m [SIZE][SIZE];
    logic [7:0]    v [SIZE];
    logic [CW-1:0] col;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            done  <= 1'b0;
            col   <= '0;
            for (int i = 0; i < SIZE; i++) begin
                v[i]       <= '0;
                vec_out[i] <= '0;
                for (int j = 0; j < SIZE; j++) m[i][j] <= '0;
            end
        end else begin
            case (state)
                COMPUTE: begin
                    // All rows consume column col in parallel; the 17-bit sum wraps for SIZE > 2.
                    for (int i = 0; i < SIZE; i++)
                        vec_out[i] <= vec_out[i] + 17'(m[i][col]) * 17'(v[col]);
                    col <= col == LAST ? '0 : col + 1'b1;
                    if (col == LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept start; operands are snapshotted so inputs may change freely.
                    if (start) begin
                        m     <= mtx_in;
                        v     <= vec_in;
                        col   <= '0;
                        done  <= 1'b0;
                        state <= COMPUTE;
                        for (int i = 0; i < SIZE; i++) vec_out[i] <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mat_vec_mul.sv
// tb_mat_vec_mul: scoreboard bench for mat_vec_mul against a plain-arithmetic reference model.
module tb_mat_vec_mul;
    localparam int SIZE = 2;
    localparam int P    = 10;
    typedef struct packed {
        logic [SIZE-1:0][16:0] v;
        longint                due;
    } exp_t;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  mtx [SIZE][SIZE];
    logic [7:0]  vec [SIZE];
    logic [16:0] vec_out [SIZE];
    logic        done;
    exp_t        qx[$];
    exp_t        e;
    int          tests = 0;
    int          fails = 0;
    longint      free_t = 0;
    logic        prev_done = 1'b0;
    always #(P/2) clk = ~clk;
    mat_vec_mul #(.SIZE(SIZE)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .mtx_in(mtx),
        .vec_in(vec),
        .vec_out(vec_out),
        .done(done)
    );
    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", n, got, want, $time);
        end
    endtask
    function automatic logic [SIZE-1:0][16:0] model();
        logic [SIZE-1:0][16:0] r;
        for (int i = 0; i < SIZE; i++) begin
            longint s = 0;
            for (int j = 0; j < SIZE; j++) s += longint'(mtx[i][j]) * longint'(vec[j]);
            r[i] = 17'(s % (1 << 17));
        end
        return r;
    endfunction
    // Called at a negedge: drive start for one rising edge, predict whether it is accepted, return at next negedge.
    task automatic cycle(input logic s);
        exp_t x;
        start = s;
        @(posedge clk);
        if (s && longint'($time) >= free_t) begin
            x.v    = model();
            x.due  = longint'($time) + SIZE * P + P / 2;
            qx.push_back(x);
            free_t = longint'($time) + (SIZE + 1) * P;
        end
        @(negedge clk);
        start = 1'b0;
    endtask
    task automatic rand_ops();
        for (int i = 0; i < SIZE; i++) begin
            vec[i] = 8'($urandom);
            for (int j = 0; j < SIZE; j++) mtx[i][j] = 8'($urandom);
        end
    endtask
    task automatic set_ops(input int a, input int b, input int c, input int d, input int x, input int y);
        mtx[0][0] = 8'(a); mtx[0][1] = 8'(b); mtx[1][0] = 8'(c); mtx[1][1] = 8'(d);
        vec[0] = 8'(x); vec[1] = 8'(y);
    endtask
    task automatic chk_out(input string n, input int a, input int b);
        chk({n, "_done"}, 32'(done), 1);
        chk({n, "_out0"}, 32'(vec_out[0]), 32'(a));
        chk({n, "_out1"}, 32'(vec_out[1]), 32'(b));
    endtask
    always @(negedge clk) begin
        if (qx.size() > 0 && longint'($time) == qx[0].due) begin
            e = qx.pop_front();
            chk("sb_done", 32'(done), 1);
            for (int i = 0; i < SIZE; i++) chk("sb_vec_out", 32'(vec_out[i]), 32'(e.v[i]));
        end else if (done && !prev_done) begin
            chk("sb_spurious_done", 32'(done && !prev_done), 0);
        end
        prev_done = done;
    end
    initial begin
        reset = 1'b1;
        start = 1'b0;
        set_ops(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_done", 32'(done), 0);
        chk("reset_out0", 32'(vec_out[0]), 0);
        chk("reset_out1", 32'(vec_out[1]), 0);
        set_ops(1, 2, 3, 4, 1, 2);
        cycle(1);
        cycle(0);
        chk("basic_done_early", 32'(done), 0);
        cycle(0);
        chk_out("basic", 5, 11);
        repeat (5) begin
            cycle(0);
            chk_out("persist", 5, 11);
        end
        set_ops(5, 6, 7, 8, 3, 4);
        cycle(1);
        chk("restart_drop", 32'(done), 0);
        cycle(0);
        cycle(0);
        chk_out("restart", 39, 53);
        set_ops(255, 255, 255, 255, 255, 255);
        cycle(1);
        rand_ops();
        cycle(1);
        cycle(0);
        chk_out("max_ignore", 130050, 130050);
        cycle(0);
        repeat (12) begin
            rand_ops();
            cycle(1);
        end
        repeat (3) cycle(0);
        repeat (40) begin
            rand_ops();
            cycle(1'($urandom_range(0, 1)));
        end
        repeat (SIZE + 2) cycle(0);
        rand_ops();
        cycle(1);
        cycle(0);
        reset = 1'b1;
        #1;
        chk("midreset_done", 32'(done), 0);
        chk("midreset_out0", 32'(vec_out[0]), 0);
        chk("midreset_out1", 32'(vec_out[1]), 0);
        qx.delete();
        free_t = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            cycle(0);
            chk("post_reset_idle", 32'(done), 0);
        end
        rand_ops();
        cycle(1);
        repeat (SIZE + 3) cycle(0);
        chk("queue_drained", 32'(qx.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
